output_mem_arbiter: RTL and testbench
=====================================

# output_mem_arbiter

Round-robin scheduler that shares the two ports of the output memory among four Winograd tile write-back requesters. Each cycle it grants up to two requests, never both to the same address, and drives registered port packages (address, data, valid) into the output memory. It sits between the PE write-back lanes and the output memory top. The scan controller stalls it through `hold` while scan-in or scan-out owns the memory.

## Interface
Parameters:
- `NREQ`, 4: number of requesters. Fixed at 4 in this revision.
- `AW`, 8: address width.
- `DW`, 512: data width.

Ports:
- `clk`  in  1  controller clock. The memory uses clk-high for its load phase and clk-low for its write phase.
- `rst`  in  1  reset, asynchronous, active-high.
- `hold`  in  1  scan owns the memory; grant nothing.
- `req_valid`  in  NREQ  request pending, one bit per requester.
- `req_ready`  out  NREQ  grant this cycle, one bit per requester.
- `req_addr`  in  NREQ×AW  target address per requester.
- `req_data`  in  NREQ×DW  write data per requester.
- `addr_1_out`, `addr_2_out`  out  AW  port address.
- `data_1_out`, `data_2_out`  out  DW  port write data.
- `package_1_valid_out`, `package_2_valid_out`  out  1  port package valid.
- `mem_data_1_in`, `mem_data_2_in`  in  DW  old contents returned by the memory during the issue cycle.
- `rsp_valid`  out  2  readback valid, bit0 = port 1, bit1 = port 2.
- `rsp_id_1`, `rsp_id_2`  out  2  requester id of the readback.
- `rsp_data_1`, `rsp_data_2`  out  DW  readback data.
- `idle`  out  1  no package in flight.
- `grant_cnt`  out  16  total grants since reset. Saturates at 0xFFFF.

## Operation
- Handshake:
  - A requester holds `req_valid` and keeps its addr/data stable until `req_valid & req_ready`.
  - `req_ready` is combinational from the current `req_valid`, `req_addr`, `rr_ptr` and `hold`.
  - A requester must never wait on `req_ready` to raise `req_valid`.
- Arbitration, each cycle with `hold`=0:
  - Scan ids in order `rr_ptr`, `rr_ptr+1`, … (mod 4).
  - The first valid id gets port 1.
  - The next valid id whose address differs from the port-1 address gets port 2.
  - A valid id with the same address as port 1 is skipped and stays pending.
- Pointer update:
  - `rr_ptr` becomes (last granted id + 1) mod 4.
  - If nothing is granted, `rr_ptr` is unchanged.
- With `hold`=1:
  - `req_ready` = 0 and no new package is issued.
  - A package registered in the previous cycle still completes.
- Issue registers:
  - On accept, the port address and data are registered and `package_N_valid_out`=1 for exactly one cycle.
  - A port with no grant drives valid 0, address 0 and data 0.
- `idle` = ~(`package_1_valid_out` | `package_2_valid_out`).
- `grant_cnt` adds popcount(`req_valid & req_ready`), i.e. 0, 1 or 2 per cycle, and saturates.
- Reset:
  - All outputs go to 0, except `idle`, which is 1.
  - `rr_ptr` = 0 and `grant_cnt` = 0.
  - Reset asserted mid-operation drops the in-flight packages immediately. Requesters must re-present.

## Timing
- Cycle T: handshake accept.
- Cycle T+1: port package valid. The memory returns the old data on `mem_data_N_in` and writes the new data in the low phase of T+1.
- Cycle T+2 (RDBACK only): `rsp_valid`, `rsp_id` and `rsp_data` are registered and valid for one cycle.
- Throughput: 2 requests/cycle, with 1 request/cycle under the same-address conflict.
- Fairness: a continuously valid requester is granted within 4 cycles, as long as `hold`=0.

## Configuration
- `OUTMEM_ARB_RDBACK_EN` defined:
  - At the end of T+1, `mem_data_N_in` is captured along with the issuing requester id.
  - `rsp_*` are driven at T+2.
- `OUTMEM_ARB_RDBACK_EN` undefined:
  - `rsp_valid`, `rsp_id_*` and `rsp_data_*` are tied to 0.
  - No capture registers are built.

## Structure
- Package `output_mem_pkg` holds:
  - `OM_AW` = 8 and `OM_DW` = 512.
  - `om_req_id_t` (logic [1:0]).
  - Struct `om_pkt_t` {valid, addr, data, id}, used for the issue and readback registers.
- One sub-module, `rr_dual_picker`: combinational. Inputs are valid, addresses and `rr_ptr`. Outputs are `grant1`/`grant2` one-hots and the next pointer.

## Test plan
- Reset, then `req_valid`=4'b0001 with addr 0x10 and data 0xAA…:
  - `req_ready[0]`=1 at T.
  - At T+1: `package_1_valid_out`=1, `addr_1_out`=0x10.
  - `package_2_valid_out`=0; `idle`=1 at T+2.
- All four requesters valid, addresses 0x01–0x04, held for 4 cycles:
  - Grants are (0,1), (2,3), (0,1), (2,3).
  - `grant_cnt`=8.
- Requesters 0 and 1 both at addr 0x20:
  - Only 0 is granted at T; 1 is granted at T+1 on port 1.
  - Never two same-address packages in one cycle.
- `hold`=1 for 3 cycles while all requesters are valid:
  - `req_ready`=0 throughout.
  - A package issued the cycle before `hold` still appears.
  - Grants resume with the `rr_ptr` value from before `hold`.
- RDBACK enabled, memory model returns 0x55… at T+1 for requester 2 on port 1:
  - At T+2: `rsp_valid`=2'b01, `rsp_id_1`=2, `rsp_data_1`=0x55….
- `rst` asserted at T+1 with a package in flight:
  - Valids are 0 immediately and `grant_cnt`=0.
  - The first grant after release goes to requester 0.

Source files
------------

// File: rtl/output_mem_pkg.sv
// Shared types and constants for the output-memory write-back arbiter.
package output_mem_pkg;

  localparam int unsigned OM_NREQ = 4;
  localparam int unsigned OM_AW   = 8;
  localparam int unsigned OM_DW   = 512;

  typedef logic [1:0] om_req_id_t;

  typedef struct packed {
    logic             valid;
    logic [OM_AW-1:0] addr;
    logic [OM_DW-1:0] data;
    om_req_id_t       id;
  } om_pkt_t;

  function automatic om_req_id_t om_onehot_to_id(input logic [OM_NREQ-1:0] oh);
    om_req_id_t id;
    id = '0;
    for (int i = 0; i < OM_NREQ; i++) begin
      if (oh[i]) id = om_req_id_t'(i);
    end
    return id;
  endfunction

endpackage

// File: rtl/output_mem_arbiter_if.sv
// Requester handshake, memory port packages and readback bundle of the arbiter.
// master = requesters / memory / scan side, slave = the arbiter.
interface output_mem_arbiter_if
  import output_mem_pkg::*;
#(
  parameter int unsigned NREQ = OM_NREQ,
  parameter int unsigned AW   = OM_AW,
  parameter int unsigned DW   = OM_DW
) ();

  logic                     hold;
  logic [NREQ-1:0]          req_valid;
  logic [NREQ-1:0]          req_ready;
  logic [NREQ-1:0][AW-1:0]  req_addr;
  logic [NREQ-1:0][DW-1:0]  req_data;
  logic [AW-1:0]            addr_1_out;
  logic [AW-1:0]            addr_2_out;
  logic [DW-1:0]            data_1_out;
  logic [DW-1:0]            data_2_out;
  logic                     package_1_valid_out;
  logic                     package_2_valid_out;
  logic [DW-1:0]            mem_data_1_in;
  logic [DW-1:0]            mem_data_2_in;
  logic [1:0]               rsp_valid;
  logic [1:0]               rsp_id_1;
  logic [1:0]               rsp_id_2;
  logic [DW-1:0]            rsp_data_1;
  logic [DW-1:0]            rsp_data_2;
  logic                     idle;
  logic [15:0]              grant_cnt;

  modport master (
    output hold, req_valid, req_addr, req_data, mem_data_1_in, mem_data_2_in,
    input  req_ready, addr_1_out, addr_2_out, data_1_out, data_2_out,
    input  package_1_valid_out, package_2_valid_out,
    input  rsp_valid, rsp_id_1, rsp_id_2, rsp_data_1, rsp_data_2, idle, grant_cnt
  );

  modport slave (
    input  hold, req_valid, req_addr, req_data, mem_data_1_in, mem_data_2_in,
    output req_ready, addr_1_out, addr_2_out, data_1_out, data_2_out,
    output package_1_valid_out, package_2_valid_out,
    output rsp_valid, rsp_id_1, rsp_id_2, rsp_data_1, rsp_data_2, idle, grant_cnt
  );

endinterface

// File: rtl/rr_dual_picker.sv
// Combinational round-robin picker: up to two grants per cycle, never to the same address.
module rr_dual_picker
  import output_mem_pkg::*;
(
  input  logic [OM_NREQ-1:0]            valid_i,
  input  logic [OM_NREQ-1:0][OM_AW-1:0] addr_i,
  input  om_req_id_t                    rr_ptr_i,
  output logic [OM_NREQ-1:0]            grant1_o,
  output logic [OM_NREQ-1:0]            grant2_o,
  output om_req_id_t                    rr_ptr_o
);

  logic             have1;
  logic             have2;
  logic [OM_AW-1:0] addr1;
  om_req_id_t       id;

  always_comb begin
    grant1_o = '0;
    grant2_o = '0;
    rr_ptr_o = rr_ptr_i;
    have1    = 1'b0;
    have2    = 1'b0;
    addr1    = '0;
    id       = rr_ptr_i;
    for (int k = 0; k < OM_NREQ; k++) begin
      id = rr_ptr_i + om_req_id_t'(k);
      if (valid_i[id]) begin
        if (!have1) begin
          have1        = 1'b1;
          grant1_o[id] = 1'b1;
          addr1        = addr_i[id];
          rr_ptr_o     = id + 2'd1;
        end else if (!have2 && (addr_i[id] != addr1)) begin
          // Same-address requesters are skipped and stay pending for a later cycle.
          have2        = 1'b1;
          grant2_o[id] = 1'b1;
          rr_ptr_o     = id + 2'd1;
        end
      end
    end
  end

endmodule

// File: rtl/output_mem_arbiter.sv
// Dual-port output-memory arbiter for four Winograd write-back requesters.
// Optional readback path enabled by defining OUTMEM_ARB_RDBACK_EN.
module output_mem_arbiter
  import output_mem_pkg::*;
(
  input logic                 clk,
  input logic                 rst,
  output_mem_arbiter_if.slave bus
);

  logic [OM_NREQ-1:0] valid_eff;
  logic [OM_NREQ-1:0] grant1;
  logic [OM_NREQ-1:0] grant2;
  om_req_id_t         rr_ptr_q, rr_ptr_d;
  om_pkt_t            pkt1_q, pkt1_d;
  om_pkt_t            pkt2_q, pkt2_d;
  logic [15:0]        grant_cnt_q, grant_cnt_d;
  logic [16:0]        cnt_sum;

  assign valid_eff = bus.hold ? '0 : bus.req_valid;

  rr_dual_picker u_picker (
    .valid_i  (valid_eff),
    .addr_i   (bus.req_addr),
    .rr_ptr_i (rr_ptr_q),
    .grant1_o (grant1),
    .grant2_o (grant2),
    .rr_ptr_o (rr_ptr_d)
  );

  assign bus.req_ready = grant1 | grant2;

  always_comb begin
    pkt1_d       = '0;
    pkt2_d       = '0;
    pkt1_d.valid = |grant1;
    pkt2_d.valid = |grant2;
    pkt1_d.id    = om_onehot_to_id(grant1);
    pkt2_d.id    = om_onehot_to_id(grant2);
    for (int i = 0; i < OM_NREQ; i++) begin
      if (grant1[i]) begin
        pkt1_d.addr = bus.req_addr[i];
        pkt1_d.data = bus.req_data[i];
      end
      if (grant2[i]) begin
        pkt2_d.addr = bus.req_addr[i];
        pkt2_d.data = bus.req_data[i];
      end
    end
  end

  always_comb begin
    cnt_sum     = {1'b0, grant_cnt_q} + 17'(pkt1_d.valid) + 17'(pkt2_d.valid);
    grant_cnt_d = cnt_sum[16] ? 16'hFFFF : cnt_sum[15:0];
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rr_ptr_q    <= '0;
      pkt1_q      <= '0;
      pkt2_q      <= '0;
      grant_cnt_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      pkt1_q      <= pkt1_d;
      pkt2_q      <= pkt2_d;
      grant_cnt_q <= grant_cnt_d;
    end
  end

  assign bus.addr_1_out          = pkt1_q.addr;
  assign bus.addr_2_out          = pkt2_q.addr;
  assign bus.data_1_out          = pkt1_q.data;
  assign bus.data_2_out          = pkt2_q.data;
  assign bus.package_1_valid_out = pkt1_q.valid;
  assign bus.package_2_valid_out = pkt2_q.valid;
  assign bus.idle                = ~(pkt1_q.valid | pkt2_q.valid);
  assign bus.grant_cnt           = grant_cnt_q;

`ifdef OUTMEM_ARB_RDBACK_EN
  om_pkt_t rsp1_q, rsp1_d;
  om_pkt_t rsp2_q, rsp2_d;
  logic    unused_rsp_addr;

  // Old memory contents are only meaningful while the matching package is on the port.
  always_comb begin
    rsp1_d = '0;
    rsp2_d = '0;
    if (pkt1_q.valid) begin
      rsp1_d.valid = 1'b1;
      rsp1_d.data  = bus.mem_data_1_in;
      rsp1_d.id    = pkt1_q.id;
    end
    if (pkt2_q.valid) begin
      rsp2_d.valid = 1'b1;
      rsp2_d.data  = bus.mem_data_2_in;
      rsp2_d.id    = pkt2_q.id;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp1_q <= '0;
      rsp2_q <= '0;
    end else begin
      rsp1_q <= rsp1_d;
      rsp2_q <= rsp2_d;
    end
  end

  assign bus.rsp_valid       = {rsp2_q.valid, rsp1_q.valid};
  assign bus.rsp_id_1        = rsp1_q.id;
  assign bus.rsp_id_2        = rsp2_q.id;
  assign bus.rsp_data_1      = rsp1_q.data;
  assign bus.rsp_data_2      = rsp2_q.data;
  assign unused_rsp_addr     = ^{rsp1_q.addr, rsp2_q.addr};
`else
  logic unused_rdback;

  assign bus.rsp_valid  = '0;
  assign bus.rsp_id_1   = '0;
  assign bus.rsp_id_2   = '0;
  assign bus.rsp_data_1 = '0;
  assign bus.rsp_data_2 = '0;
  assign unused_rdback  = ^{bus.mem_data_1_in, bus.mem_data_2_in, pkt1_q.id, pkt2_q.id};
`endif

endmodule

// File: tb/tb_output_mem_arbiter.sv
// Self-checking bench for output_mem_arbiter (table vectors, corner sequences, random traffic).
module tb_output_mem_arbiter;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  output_mem_arbiter_if bus ();

  output_mem_arbiter dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int n_vec = 0;
  int n_bad = 0;

  // Reference model state
  int           m_ptr;
  int           m_cnt;
  logic         m_v1, m_v2;
  logic [7:0]   m_a1, m_a2;
  logic [511:0] m_d1, m_d2;
  logic [1:0]   m_id1, m_id2;
  logic         m_rv1, m_rv2;
  logic [1:0]   m_rid1, m_rid2;
  logic [511:0] m_rd1, m_rd2;
  logic [3:0]   m_last;

  typedef struct {
    logic [3:0]      valid;
    logic [3:0][7:0] addr;
    logic            hold;
    logic [3:0]      exp_ready;
    int              exp_cnt;
  } vec_t;

  vec_t tbl[12];

  function automatic void chk(input string name, input logic [511:0] act,
                              input logic [511:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endfunction

  function automatic logic [511:0] rnd512();
    logic [511:0] r;
    for (int i = 0; i < 16; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic vec_t mk(input logic [3:0] v, input logic [7:0] a0, input logic [7:0] a1,
                              input logic [7:0] a2, input logic [7:0] a3, input logic h,
                              input logic [3:0] r, input int c);
    vec_t x;
    x.valid     = v;
    x.addr      = {a3, a2, a1, a0};
    x.hold      = h;
    x.exp_ready = r;
    x.exp_cnt   = c;
    return x;
  endfunction

  function automatic void model_reset();
    m_ptr = 0; m_cnt = 0; m_last = '0;
    m_v1 = 0; m_v2 = 0; m_a1 = '0; m_a2 = '0; m_d1 = '0; m_d2 = '0; m_id1 = '0; m_id2 = '0;
    m_rv1 = 0; m_rv2 = 0; m_rid1 = '0; m_rid2 = '0; m_rd1 = '0; m_rd2 = '0;
  endfunction

  // Scan valid ids from the pointer; first wins port 1, next with a different address port 2.
  function automatic void pick(input logic [3:0] v, input logic [3:0][7:0] a, input logic h,
                               output int p1, output int p2);
    int order[$];
    p1 = -1;
    p2 = -1;
    if (h) return;
    for (int k = 0; k < 4; k++) if (v[(m_ptr + k) % 4]) order.push_back((m_ptr + k) % 4);
    if (order.size() > 0) p1 = order[0];
    for (int i = 1; i < order.size(); i++) begin
      if (p2 < 0 && a[order[i]] != a[p1]) p2 = order[i];
    end
  endfunction

  task automatic step(input logic use_exp, input logic [3:0] exp);
    logic [3:0]        v;
    logic [3:0][7:0]   a;
    logic [3:0][511:0] d;
    logic              h;
    logic [511:0]      md1, md2;
    logic [3:0]        g;
    int                p1, p2;
    v = bus.req_valid; a = bus.req_addr; d = bus.req_data; h = bus.hold;
    pick(v, a, h, p1, p2);
    g = '0;
    if (p1 >= 0) g[p1] = 1'b1;
    if (p2 >= 0) g[p2] = 1'b1;
    m_last = g;
    @(negedge clk);
    chk("req_ready", {508'd0, bus.req_ready}, {508'd0, g});
    if (use_exp) chk("tbl_ready", {508'd0, bus.req_ready}, {508'd0, exp});
    md1 = bus.mem_data_1_in;
    md2 = bus.mem_data_2_in;
    @(posedge clk);
    #1;
    m_rv1 = m_v1; m_rid1 = m_v1 ? m_id1 : 2'd0; m_rd1 = m_v1 ? md1 : '0;
    m_rv2 = m_v2; m_rid2 = m_v2 ? m_id2 : 2'd0; m_rd2 = m_v2 ? md2 : '0;
    m_v1 = 0; m_a1 = '0; m_d1 = '0; m_id1 = '0;
    m_v2 = 0; m_a2 = '0; m_d2 = '0; m_id2 = '0;
    if (p1 >= 0) begin m_v1 = 1; m_a1 = a[p1]; m_d1 = d[p1]; m_id1 = 2'(p1); m_cnt++; end
    if (p2 >= 0) begin m_v2 = 1; m_a2 = a[p2]; m_d2 = d[p2]; m_id2 = 2'(p2); m_cnt++; end
    if (m_cnt > 65535) m_cnt = 65535;
    if (p2 >= 0) m_ptr = (p2 + 1) % 4;
    else if (p1 >= 0) m_ptr = (p1 + 1) % 4;
    chk("pkg1_valid", {511'd0, bus.package_1_valid_out}, {511'd0, m_v1});
    chk("pkg2_valid", {511'd0, bus.package_2_valid_out}, {511'd0, m_v2});
    chk("addr_1", {504'd0, bus.addr_1_out}, {504'd0, m_a1});
    chk("addr_2", {504'd0, bus.addr_2_out}, {504'd0, m_a2});
    chk("data_1", bus.data_1_out, m_d1);
    chk("data_2", bus.data_2_out, m_d2);
    chk("idle", {511'd0, bus.idle}, {511'd0, ~(m_v1 | m_v2)});
    chk("grant_cnt", {496'd0, bus.grant_cnt}, 512'(m_cnt));
`ifdef OUTMEM_ARB_RDBACK_EN
    chk("rsp_valid", {510'd0, bus.rsp_valid}, {510'd0, m_rv2, m_rv1});
    chk("rsp_id_1", {510'd0, bus.rsp_id_1}, {510'd0, m_rid1});
    chk("rsp_id_2", {510'd0, bus.rsp_id_2}, {510'd0, m_rid2});
    chk("rsp_data_1", bus.rsp_data_1, m_rd1);
    chk("rsp_data_2", bus.rsp_data_2, m_rd2);
`else
    chk("rsp_tied", {bus.rsp_valid, bus.rsp_id_1, bus.rsp_id_2} ^ bus.rsp_data_1
        ^ bus.rsp_data_2, '0);
`endif
  endtask

  task automatic drive_distinct_all();
    bus.req_valid = 4'b1111;
    for (int i = 0; i < 4; i++) begin
      bus.req_addr[i] = 8'(i + 1);
      bus.req_data[i] = rnd512();
    end
  endtask

  initial begin
    rst = 1'b1;
    bus.hold = 1'b0;
    bus.req_valid = '0;
    bus.req_addr = '0;
    bus.req_data = '0;
    bus.mem_data_1_in = '0;
    bus.mem_data_2_in = '0;
    model_reset();

    tbl[0]  = mk(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4'b0011, 2);
    tbl[1]  = mk(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4'b1100, 4);
    tbl[2]  = mk(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4'b0011, 6);
    tbl[3]  = mk(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b0, 4'b1100, 8);
    tbl[4]  = mk(4'b0011, 8'h20, 8'h20, 8'h00, 8'h00, 1'b0, 4'b0001, 9);
    tbl[5]  = mk(4'b0010, 8'h20, 8'h20, 8'h00, 8'h00, 1'b0, 4'b0010, 10);
    tbl[6]  = mk(4'b1111, 8'h01, 8'h02, 8'h03, 8'h04, 1'b1, 4'b0000, 10);
    tbl[7]  = mk(4'b0101, 8'h05, 8'h00, 8'h05, 8'h00, 1'b0, 4'b0100, 11);
    tbl[8]  = mk(4'b1001, 8'h07, 8'h00, 8'h00, 8'h08, 1'b0, 4'b1001, 13);
    tbl[9]  = mk(4'b0000, 8'h00, 8'h00, 8'h00, 8'h00, 1'b0, 4'b0000, 13);
    tbl[10] = mk(4'b1100, 8'h00, 8'h00, 8'h09, 8'h09, 1'b0, 4'b0100, 14);
    tbl[11] = mk(4'b1010, 8'h00, 8'h01, 8'h00, 8'h02, 1'b0, 4'b1010, 16);

    // Reset state
    #12;
    chk("rst_pkg_valid", {510'd0, bus.package_1_valid_out, bus.package_2_valid_out}, '0);
    chk("rst_addr", {496'd0, bus.addr_1_out, bus.addr_2_out}, '0);
    chk("rst_data", bus.data_1_out | bus.data_2_out, '0);
    chk("rst_idle", {511'd0, bus.idle}, 512'd1);
    chk("rst_cnt", {496'd0, bus.grant_cnt}, '0);
    chk("rst_rsp", {506'd0, bus.rsp_valid, bus.rsp_id_1, bus.rsp_id_2}, '0);
    chk("rst_ready", {508'd0, bus.req_ready}, '0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Table-driven vectors from the post-reset pointer
    for (int t = 0; t < 12; t++) begin
      bus.req_valid = tbl[t].valid;
      bus.req_addr  = tbl[t].addr;
      bus.hold      = tbl[t].hold;
      for (int i = 0; i < 4; i++) bus.req_data[i] = rnd512();
      step(1'b1, tbl[t].exp_ready);
      chk("tbl_cnt", {496'd0, bus.grant_cnt}, 512'(tbl[t].exp_cnt));
      if (bus.package_1_valid_out && bus.package_2_valid_out)
        chk("tbl_addr_distinct", {511'd0, bus.addr_1_out != bus.addr_2_out}, 512'd1);
    end
    bus.hold = 1'b0;

    // Single request, port 1 only, idle again two cycles later
    bus.req_valid = 4'b0001;
    bus.req_addr[0] = 8'h10;
    bus.req_data[0] = {64{8'hAA}};
    step(1'b1, 4'b0001);
    chk("single_pkg1", {511'd0, bus.package_1_valid_out}, 512'd1);
    chk("single_addr1", {504'd0, bus.addr_1_out}, 512'h10);
    chk("single_data1", bus.data_1_out, {64{8'hAA}});
    chk("single_pkg2", {511'd0, bus.package_2_valid_out}, '0);
    bus.req_valid = '0;
    step(1'b0, '0);
    chk("single_idle", {511'd0, bus.idle}, 512'd1);

    // Hold: package issued before hold still shows, grants resume from saved pointer.
    // Pointer is 1 here, so all-valid grants (1,2), leaving the pointer at 3.
    drive_distinct_all();
    step(1'b1, 4'b0110);
    bus.hold = 1'b1;
    #1;
    chk("hold_inflight", {510'd0, bus.package_1_valid_out, bus.package_2_valid_out}, 512'd3);
    for (int c = 0; c < 3; c++) begin
      drive_distinct_all();
      step(1'b1, 4'b0000);
    end
    bus.hold = 1'b0;
    #1;
    chk("hold_resume", {508'd0, bus.req_ready}, 512'b1001);
    step(1'b1, 4'b1001);

`ifdef OUTMEM_ARB_RDBACK_EN
    // Readback of old memory contents for requester 2 on port 1
    bus.req_valid = 4'b0100;
    bus.req_addr[2] = 8'h33;
    bus.req_data[2] = rnd512();
    step(1'b1, 4'b0100);
    bus.req_valid = '0;
    bus.mem_data_1_in = {64{8'h55}};
    step(1'b0, '0);
    chk("rdback_valid", {510'd0, bus.rsp_valid}, 512'b01);
    chk("rdback_id", {510'd0, bus.rsp_id_1}, 512'd2);
    chk("rdback_data", bus.rsp_data_1, {64{8'h55}});
`endif

    // Reset with a package in flight
    bus.req_valid = 4'b1000;
    bus.req_addr[3] = 8'h44;
    step(1'b1, 4'b1000);
    rst = 1'b1;
    #1;
    chk("midrst_valid", {510'd0, bus.package_1_valid_out, bus.package_2_valid_out}, '0);
    chk("midrst_cnt", {496'd0, bus.grant_cnt}, '0);
    chk("midrst_idle", {511'd0, bus.idle}, 512'd1);
    model_reset();
    bus.req_valid = '0;
    bus.mem_data_1_in = '0;
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    drive_distinct_all();
    step(1'b1, 4'b0011);
    chk("midrst_first_addr", {504'd0, bus.addr_1_out}, 512'h01);

    // Randomized traffic with requesters holding until accepted
    bus.req_valid = '0;
    for (int c = 0; c < 400; c++) begin
      for (int i = 0; i < 4; i++) begin
        if (!bus.req_valid[i] && $urandom_range(0, 2) != 0) begin
          bus.req_valid[i] = 1'b1;
          bus.req_addr[i]  = 8'($urandom_range(0, 3));
          bus.req_data[i]  = rnd512();
        end
      end
      bus.hold = ($urandom_range(0, 9) == 0);
      bus.mem_data_1_in = rnd512();
      bus.mem_data_2_in = rnd512();
      step(1'b0, '0);
      bus.req_valid = bus.req_valid & ~m_last;
      if (bus.package_1_valid_out && bus.package_2_valid_out)
        chk("rand_addr_distinct", {511'd0, bus.addr_1_out != bus.addr_2_out}, 512'd1);
    end

    // Saturation of the grant counter
    bus.hold = 1'b0;
    drive_distinct_all();
    repeat (33000) @(posedge clk);
    #1;
    chk("cnt_saturate", {496'd0, bus.grant_cnt}, 512'hFFFF);
    repeat (3) @(posedge clk);
    #1;
    chk("cnt_stays_sat", {496'd0, bus.grant_cnt}, 512'hFFFF);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
